// File: rtl/fxp_multiplier_if.sv
// Streaming operand/result bundle for fxp_multiplier.
// The master modport is the side that supplies operands and consumes results; the slave modport is the multiplier.
interface fxp_multiplier_if #(
  parameter int C_FXP_LENGTH = 16
);
  logic signed [C_FXP_LENGTH-1:0] S_NUM1;
  logic signed [C_FXP_LENGTH-1:0] S_NUM2;
  logic                           S_IN_VALID;
  logic                           S_IN_READY;
  logic signed [C_FXP_LENGTH-1:0] M_RESULT;
  logic                           M_OF_FLAG;
  logic                           M_OUT_VALID;
  logic                           M_OUT_READY;

  modport master (
    output S_NUM1, S_NUM2, S_IN_VALID, M_OUT_READY,
    input  S_IN_READY, M_RESULT, M_OF_FLAG, M_OUT_VALID
  );

  modport slave (
    input  S_NUM1, S_NUM2, S_IN_VALID, M_OUT_READY,
    output S_IN_READY, M_RESULT, M_OF_FLAG, M_OUT_VALID
  );
endinterface

// File: rtl/fxp_multiplier.sv
// Three-stage signed fixed-point multiplier: register operands, full product, then round-half-up and saturate.
// The whole pipe stalls as one unit whenever a valid result is waiting on downstream ready.
module fxp_multiplier #(
  parameter int C_FXP_LENGTH = 16,
  parameter int C_FXP_POINT  = 12
) (
  input logic S_ACLK,
  input logic S_ARESETN,
  fxp_multiplier_if.slave bus
);
  localparam int W  = C_FXP_LENGTH;
  localparam int PW = 2 * C_FXP_LENGTH;

  localparam logic signed [PW-1:0] HALF    = {{(PW-1){1'b0}}, 1'b1} << (C_FXP_POINT - 1);
  localparam logic        [W-1:0]  MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic        [W-1:0]  MAX_NEG = {1'b1, {(W-1){1'b0}}};

  function automatic logic signed [PW-1:0] round_half_up(input logic signed [PW-1:0] p);
    return (p + HALF) >>> C_FXP_POINT;
  endfunction

  // Result fits when every bit from the output sign bit upward agrees; returns {overflow, data}.
  function automatic logic [W:0] saturate(input logic signed [PW-1:0] r);
    logic [PW-W:0] hi;
    hi = r[PW-1:W-1];
    if ((&hi) || (~|hi)) return {1'b0, r[W-1:0]};
    return r[PW-1] ? {1'b1, MAX_NEG} : {1'b1, MAX_POS};
  endfunction

  logic                   en;
  logic signed [W-1:0]    num1_p0;
  logic signed [W-1:0]    num2_p0;
  logic                   vld_p0;
  logic signed [PW-1:0]   prod_p1;
  logic                   vld_p1;
  logic signed [W-1:0]    result_p2;
  logic                   of_p2;
  logic                   vld_p2;
  logic signed [PW-1:0]   rounded;
  logic        [W:0]      sat;

  assign en              = !vld_p2 || bus.M_OUT_READY;
  assign bus.S_IN_READY  = en;
  assign bus.M_RESULT    = result_p2;
  assign bus.M_OF_FLAG   = of_p2;
  assign bus.M_OUT_VALID = vld_p2;

  assign rounded = round_half_up(prod_p1);
  assign sat     = saturate(rounded);

  always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
    if (!S_ARESETN) begin
      num1_p0   <= '0;
      num2_p0   <= '0;
      vld_p0    <= 1'b0;
      prod_p1   <= '0;
      vld_p1    <= 1'b0;
      result_p2 <= '0;
      of_p2     <= 1'b0;
      vld_p2    <= 1'b0;
    end else if (en) begin
      // stage 0: operand capture
      num1_p0   <= bus.S_NUM1;
      num2_p0   <= bus.S_NUM2;
      vld_p0    <= bus.S_IN_VALID;
      // stage 1: full-width signed product
      prod_p1   <= PW'(num1_p0) * PW'(num2_p0);
      vld_p1    <= vld_p0;
      // stage 2: round and saturate back to input format
      result_p2 <= sat[W-1:0];
      of_p2     <= sat[W];
      vld_p2    <= vld_p1;
    end
  end
endmodule

// File: tb/tb_fxp_multiplier.sv
// Bench for fxp_multiplier: directed literal vectors plus an arithmetic reference model scoreboard
// checked on every cycle, covering latency, saturation, rounding, backpressure, random traffic and async reset.
module tb_fxp_multiplier;
  localparam int W = 16;
  localparam int F = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fxp_multiplier_if #(.C_FXP_LENGTH(W)) bus ();

  fxp_multiplier #(.C_FXP_LENGTH(W), .C_FXP_POINT(F)) dut (
    .S_ACLK(clk),
    .S_ARESETN(rst_n),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [W:0] exp_q[$];
  logic       hold_armed = 1'b0;
  logic [W:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer product, add half an LSB, floor-divide by 2^F, clamp to the signed range.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p, r, maxp, minn;
    logic [63:0] rb;
    maxp = (longint'(1) <<< (W - 1)) - 1;
    minn = -(longint'(1) <<< (W - 1));
    p = longint'($signed(a)) * longint'($signed(b));
    r = (p + (longint'(1) <<< (F - 1))) >>> F;
    if (r > maxp) return {1'b1, 1'b0, {(W-1){1'b1}}};
    if (r < minn) return {1'b1, 1'b1, {(W-1){1'b0}}};
    rb = r;
    return {1'b0, rb[W-1:0]};
  endfunction

  always @(negedge rst_n) begin
    exp_q.delete();
    hold_armed = 1'b0;
  end

  // Scoreboard: sampled on the falling edge, judging what the next rising edge will transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", {31'd0, bus.S_IN_READY}, {31'd0, (!bus.M_OUT_VALID || bus.M_OUT_READY)});
      if (hold_armed)
        check("hold_stable", {15'd0, bus.M_OF_FLAG, bus.M_RESULT}, {15'd0, held});
      hold_armed = bus.M_OUT_VALID && !bus.M_OUT_READY;
      held = {bus.M_OF_FLAG, bus.M_RESULT};
      if (bus.M_OUT_VALID && bus.M_OUT_READY) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h with no item outstanding at %0t", bus.M_RESULT, $time);
        end else begin
          check("sb_result_of", {15'd0, bus.M_OF_FLAG, bus.M_RESULT}, {15'd0, exp_q.pop_front()});
        end
      end
      if (bus.S_IN_VALID && bus.S_IN_READY)
        exp_q.push_back(model(bus.S_NUM1, bus.S_NUM2));
    end
  end

  // Present one operand pair from posedge+1 until it is accepted; returns at posedge+1 after acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    logic acc;
    acc = 1'b0;
    bus.S_NUM1 = a;
    bus.S_NUM2 = b;
    bus.S_IN_VALID = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.S_IN_READY;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: operand 0x%0h not accepted, required accept within 200 cycles", a);
    end
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic eof, input bit chk_lat);
    int lat;
    logic got;
    check({"model_", name}, {15'd0, model(a, b)}, {15'd0, eof, er});
    @(posedge clk);
    #1;
    bus.M_OUT_READY = 1'b1;
    send(a, b);
    bus.S_IN_VALID = 1'b0;
    lat = 1;
    got = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.M_OUT_VALID) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: M_OUT_VALID never rose, required within 20 cycles", name);
    end else begin
      check({name, "_result"}, {16'd0, bus.M_RESULT}, {16'd0, er});
      check({name, "_of"}, {31'd0, bus.M_OF_FLAG}, {31'd0, eof});
      if (chk_lat) check({name, "_latency"}, lat, 3);
    end
    @(posedge clk);
    #1;
  endtask

  logic rnd_done = 1'b0;

  initial begin
    bus.S_NUM1 = '0;
    bus.S_NUM2 = '0;
    bus.S_IN_VALID = 1'b0;
    bus.M_OUT_READY = 1'b1;
    #23;
    check("rst_out_valid", {31'd0, bus.M_OUT_VALID}, 32'd0);
    check("rst_result", {16'd0, bus.M_RESULT}, 32'd0);
    check("rst_of", {31'd0, bus.M_OF_FLAG}, 32'd0);
    rst_n = 1'b1;
    #2;
    check("rst_in_ready", {31'd0, bus.S_IN_READY}, 32'd1);

    directed("basic",    16'h1800, 16'h2000, 16'h3000, 1'b0, 1'b1);
    directed("sat_pos",  16'h4000, 16'h4000, 16'h7FFF, 1'b1, 1'b0);
    directed("sat_neg",  16'hC000, 16'h4000, 16'h8000, 1'b1, 1'b0);
    directed("minmin",   16'h8000, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    directed("exact_neg",16'h8000, 16'h1000, 16'h8000, 1'b0, 1'b0);
    directed("rnd_up",   16'h0001, 16'h0800, 16'h0001, 1'b0, 1'b0);
    directed("rnd_negh", 16'hFFFF, 16'h0800, 16'h0000, 1'b0, 1'b0);
    directed("rnd_down", 16'h0001, 16'h07FF, 16'h0000, 1'b0, 1'b0);

    // Backpressure: six back-to-back items with a four-cycle output stall in the middle.
    n_out = 0;
    fork
      begin
        send(16'h1000, 16'h1000);
        send(16'h2000, 16'h3000);
        send(16'hE000, 16'h1800);
        send(16'h7FFF, 16'h7FFF);
        send(16'h0123, 16'hF456);
        send(16'h8000, 16'h1000);
        bus.S_IN_VALID = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        bus.M_OUT_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("stall_in_ready", {31'd0, bus.S_IN_READY}, 32'd0);
          @(posedge clk);
          #1;
        end
        bus.M_OUT_READY = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check("bp_count", n_out, 6);
    check("bp_drained", exp_q.size(), 0);

    // Random traffic: 1000 accepted items, random input gaps and random downstream ready.
    n_out = 0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [W-1:0] a, b;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          a = W'($urandom);
          b = W'($urandom);
          if ($urandom_range(0, 7) == 0) a = 16'h8000;
          if ($urandom_range(0, 7) == 0) b = 16'h7FFF;
          send(a, b);
          bus.S_IN_VALID = 1'b0;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.M_OUT_READY = ($urandom_range(0, 3) != 0);
        end
        bus.M_OUT_READY = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    check("rand_count", n_out, 1000);
    check("rand_drained", exp_q.size(), 0);

    // Asynchronous reset with three items in flight.
    bus.M_OUT_READY = 1'b1;
    send(16'h1000, 16'h2000);
    send(16'h3000, 16'h0800);
    send(16'h4000, 16'h4000);
    bus.S_IN_VALID = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, bus.M_OUT_VALID}, 32'd0);
    check("arst_result", {16'd0, bus.M_RESULT}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("arst_no_stale", {31'd0, bus.M_OUT_VALID}, 32'd0);
    end
    directed("post_rst", 16'h1800, 16'h2000, 16'h3000, 1'b0, 1'b1);
    check("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded 2000000 time units");
    $fatal(1, "timeout");
  end
endmodule
